vc_test_rand_delay_queue: RTL

//  Test-harness val/rdy stage between a source/sink and a DUT. Buffers up to
//  p_num_entries messages and holds each head message for a per-message delay

---
 rtl/vc_test_rand_delay_queue_pkg.sv | 22 ++
 rtl/vc_test_lfsr32.sv | 33 +++
 rtl/vc_test_rand_delay_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/vc_test_rand_delay_queue_pkg.sv
// Shared constants for the random-delay queue and its companion test sources/sinks:
// LFSR feedback mask, default seed and the single-step LFSR function.
package vc_test_rand_delay_queue_pkg;

    // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] LFSR_SEED = 32'hACE12F5B;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

    function automatic logic is_pow2_ge2(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vc_test_lfsr32.sv
// 32-bit Galois LFSR, seedable by parameter; advances one step per cycle with en=1.
module vc_test_lfsr32
    import vc_test_rand_delay_queue_pkg::*;
#(
    parameter logic [31:0] p_seed = LFSR_SEED
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= p_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/vc_test_rand_delay_queue.sv
// Val/rdy buffering stage that holds each head message for a seeded pseudo-random
// number of cycles in [p_min_delay, p_max_delay] before presenting it downstream.
module vc_test_rand_delay_queue
    import vc_test_rand_delay_queue_pkg::*;
#(
    parameter int unsigned p_msg_sz      = 1,
    parameter int unsigned p_num_entries = 2,
    parameter int unsigned p_min_delay   = 0,
    parameter int unsigned p_max_delay   = 0,
    parameter logic [31:0] p_seed        = LFSR_SEED
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                delay_en,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [p_msg_sz-1:0] in_msg,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [p_msg_sz-1:0] out_msg
);

    localparam int unsigned      PTR_W = $clog2(p_num_entries);
    localparam int unsigned      CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(p_num_entries);
    localparam logic [31:0]      MIN_D = 32'(p_min_delay);
    localparam logic [31:0]      RANGE = 32'(p_max_delay - p_min_delay + 1);

    if (p_max_delay < p_min_delay) begin : g_bad_delay
        $error("vc_test_rand_delay_queue: p_max_delay must be >= p_min_delay");
    end
    if (p_seed == 32'd0) begin : g_bad_seed
        $error("vc_test_rand_delay_queue: p_seed must be nonzero");
    end
    if (!is_pow2_ge2(p_num_entries)) begin : g_bad_depth
        $error("vc_test_rand_delay_queue: p_num_entries must be a power of 2, >= 2");
    end

    logic [p_msg_sz-1:0] mem_q [p_num_entries];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [31:0]         delay_cnt_q, delay_cnt_d;
    logic [31:0]         lfsr;
    logic [31:0]         draw_val;
    logic                empty;
    logic                enq;
    logic                deq;
    logic                draw;

    assign empty   = (count_q == '0);
    assign in_rdy  = !reset && (count_q != FULL);
    assign out_val = !reset && !empty && (delay_cnt_q == '0);
    assign out_msg = mem_q[rd_ptr_q];

    assign enq = in_val && in_rdy;
    assign deq = out_val && out_rdy;

    // A new head appears on enqueue into an empty buffer, or when a dequeue
    // leaves at least one message behind (including enq+deq at count==1).
    assign draw = (enq && empty) || (deq && ((count_q > CNT_W'(1)) || enq));

    vc_test_lfsr32 #(
        .p_seed (p_seed)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (draw),
        .q     (lfsr)
    );

    always_comb begin
        draw_val = '0;
        if (delay_en) begin
            if (p_min_delay == p_max_delay) begin
                draw_val = MIN_D;
            end else begin
                draw_val = MIN_D + (lfsr % RANGE);
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        delay_cnt_d = delay_cnt_q;

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
        end

        if (draw) begin
            delay_cnt_d = draw_val;
        end else if (!empty && (delay_cnt_q != '0)) begin
            delay_cnt_d = delay_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            delay_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            delay_cnt_q <= delay_cnt_d;
        end
    end

    // Storage needs no reset: contents are only observed when count says valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= in_msg;
        end
    end

endmodule
